omega_ramp_ctrl: RTL and testbench

//  Sequences frequency-word (omega) updates between the SPI command path and the NCO phase accumulator.

---
 rtl/omega_ramp_ctrl_pkg.sv | 13 +
 rtl/omega_ramp_ctrl_if.sv | 31 +++
 rtl/omega_ramp_ctrl_tick_gen.sv | 34 +++
 rtl/omega_ramp_ctrl.sv | 132 +++++++++++++
 tb/tb_omega_ramp_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/omega_ramp_ctrl_pkg.sv
// Shared defaults and state encoding for the omega ramp controller.
package omega_pkg;

   localparam int OMEGA_W_DEF = 64;
   localparam int DIV_W_DEF   = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RAMP = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/omega_ramp_ctrl_if.sv
// Target-omega command channel: target word, slew step and rate divider with valid/ready.
interface omega_ramp_ctrl_if
   import omega_pkg::*;
#(
   parameter int OMEGA_W = OMEGA_W_DEF,
   parameter int DIV_W   = DIV_W_DEF
);

   logic [OMEGA_W-1:0] tgt_omega;
   logic [OMEGA_W-1:0] tgt_step;
   logic [DIV_W-1:0]   tgt_div;
   logic               tgt_valid;
   logic               tgt_ready;

   modport master (
      output tgt_omega,
      output tgt_step,
      output tgt_div,
      output tgt_valid,
      input  tgt_ready
   );

   modport slave (
      input  tgt_omega,
      input  tgt_step,
      input  tgt_div,
      input  tgt_valid,
      output tgt_ready
   );

endinterface

// File: rtl/omega_ramp_ctrl_tick_gen.sv
// Rate prescaler: counts enabled cycles 0..div and flags the last one as a tick.
module omega_tick_gen
   import omega_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] r_cnt;

   assign tick = en && (r_cnt == div);

   // Prescaler count: clear wins, otherwise advance on enable and wrap at the tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         if (tick) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/omega_ramp_ctrl.sv
// Omega ramp controller: slews the NCO frequency word toward a commanded target in clamped steps.
module omega_ramp_ctrl
   import omega_pkg::*;
#(
   parameter int                 OMEGA_W   = OMEGA_W_DEF,
   parameter int                 DIV_W     = DIV_W_DEF,
   parameter logic [OMEGA_W-1:0] OMEGA_RST = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   omega_ramp_ctrl_if.slave    s_tgt,
   input  logic                enable,
   output logic [OMEGA_W-1:0]  omega,
   output logic                busy,
   output logic                done
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [OMEGA_W-1:0] r_omega;
   logic [OMEGA_W-1:0] r_tgt;
   logic [OMEGA_W-1:0] r_step;
   logic [DIV_W-1:0]   r_div;

   logic               w_xfer;
   logic               w_imm;
   logic               w_tick;
   logic               w_load;
   logic               w_jump;
   logic               w_upd;
   logic [OMEGA_W:0]   w_diff;
   logic               w_up;
   logic [OMEGA_W:0]   w_mag;
   logic               w_close;
   logic [OMEGA_W-1:0] w_addend;
   logic [OMEGA_W-1:0] w_sum;

   assign s_tgt.tgt_ready = (r_state != DONE);
   assign w_xfer          = s_tgt.tgt_valid && s_tgt.tgt_ready;
   // A zero step or an already-matching target is applied in one edge with no ramp.
   assign w_imm           = (s_tgt.tgt_step == '0) || (s_tgt.tgt_omega == r_omega);

   omega_tick_gen #(
      .DIV_W (DIV_W)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_xfer),
      .en    (enable && (r_state == RAMP)),
      .div   (r_div),
      .tick  (w_tick)
   );

   // Direction and distance use one extra bit so the sign of target-omega is never lost.
   assign w_diff   = {1'b0, r_tgt} - {1'b0, r_omega};
   assign w_up     = ~w_diff[OMEGA_W];
   assign w_mag    = w_up ? w_diff : ({1'b0, r_omega} - {1'b0, r_tgt});
   assign w_close  = (w_mag <= {1'b0, r_step});
   // Single adder: subtract is omega + ~step + 1.
   assign w_addend = w_up ? r_step : ~r_step;
   assign w_sum    = r_omega + w_addend + {{(OMEGA_W-1){1'b0}}, ~w_up};

   assign omega = r_omega;
   assign busy  = (r_state == RAMP);
   assign done  = (r_state == DONE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and datapath strobes; a transfer takes priority over a coincident tick.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_jump      = 1'b0;
      w_upd       = 1'b0;
      case (r_state)
         IDLE, RAMP: begin
            if (w_xfer) begin
               w_load = 1'b1;
               if (w_imm) begin
                  w_jump      = 1'b1;
                  w_state_nxt = DONE;
               end else begin
                  w_state_nxt = RAMP;
               end
            end else if ((r_state == RAMP) && w_tick) begin
               w_upd = 1'b1;
               if (w_close) begin
                  w_state_nxt = DONE;
               end
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Command registers captured on every accepted transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tgt  <= '0;
         r_step <= '0;
         r_div  <= '0;
      end else if (w_load) begin
         r_tgt  <= s_tgt.tgt_omega;
         r_step <= s_tgt.tgt_step;
         r_div  <= s_tgt.tgt_div;
      end
   end

   // Live omega: immediate jump, or one clamped step per tick so it never passes the target.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_omega <= OMEGA_RST;
      end else if (w_jump) begin
         r_omega <= s_tgt.tgt_omega;
      end else if (w_upd) begin
         r_omega <= w_close ? r_tgt : w_sum;
      end
   end

endmodule

// File: tb/tb_omega_ramp_ctrl.sv
// Self-checking bench for omega_ramp_ctrl: directed scenarios plus randomized ramps and retargets.
module tb_omega_ramp_ctrl;
   import omega_pkg::*;

   localparam int OW = 64;
   localparam int DW = 16;
   localparam logic [OW-1:0] MAXV = {OW{1'b1}};

   localparam int M_IDLE = 0;
   localparam int M_RAMP = 1;
   localparam int M_DONE = 2;

   logic          clk;
   logic          rst_n;
   logic          enable;
   logic [OW-1:0] omega;
   logic          busy;
   logic          done;

   omega_ramp_ctrl_if #(.OMEGA_W(OW), .DIV_W(DW)) u_if ();

   omega_ramp_ctrl #(.OMEGA_W(OW), .DIV_W(DW), .OMEGA_RST('0)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .s_tgt  (u_if),
      .enable (enable),
      .omega  (omega),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: live word, latched command, cycles left until the next update.
   logic [OW-1:0] m_om;
   logic [OW-1:0] m_tgt;
   logic [OW-1:0] m_step;
   int            m_div;
   int            m_wait;
   int            m_mode;

   task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_om   = '0;
      m_tgt  = '0;
      m_step = '0;
      m_div  = 0;
      m_wait = 0;
      m_mode = M_IDLE;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ":omega"}, omega, m_om);
      chk({tag, ":busy"},  {63'd0, busy}, {63'd0, (m_mode == M_RAMP)});
      chk({tag, ":done"},  {63'd0, done}, {63'd0, (m_mode == M_DONE)});
      chk({tag, ":ready"}, {63'd0, u_if.tgt_ready}, {63'd0, (m_mode != M_DONE)});
   endtask

   // One clock: advance the model from the inputs held across the edge, then compare on the falling edge.
   task automatic cycle(input string tag);
      logic xfer;
      @(posedge clk);
      xfer = u_if.tgt_valid && (m_mode != M_DONE);
      if (xfer) begin
         m_tgt  = u_if.tgt_omega;
         m_step = u_if.tgt_step;
         m_div  = int'(u_if.tgt_div);
         if (u_if.tgt_step == '0 || u_if.tgt_omega == m_om) begin
            m_om   = u_if.tgt_omega;
            m_mode = M_DONE;
         end else begin
            m_mode = M_RAMP;
            m_wait = m_div + 1;
         end
      end else if (m_mode == M_DONE) begin
         m_mode = M_IDLE;
      end else if (m_mode == M_RAMP && enable) begin
         m_wait--;
         if (m_wait == 0) begin
            m_wait = m_div + 1;
            if (m_tgt > m_om) m_om = (m_tgt - m_om <= m_step) ? m_tgt : m_om + m_step;
            else              m_om = (m_om - m_tgt <= m_step) ? m_tgt : m_om - m_step;
            if (m_om == m_tgt) m_mode = M_DONE;
         end
      end
      @(negedge clk);
      check_outputs(tag);
   endtask

   task automatic send(input string tag, input logic [OW-1:0] t, input logic [OW-1:0] s, input int d);
      u_if.tgt_omega = t;
      u_if.tgt_step  = s;
      u_if.tgt_div   = DW'(d);
      u_if.tgt_valid = 1'b1;
      cycle(tag);
      u_if.tgt_valid = 1'b0;
   endtask

   task automatic run_idle(input string tag, input int limit);
      for (int i = 0; i < limit; i++) begin
         if (m_mode == M_IDLE) break;
         cycle(tag);
      end
      chk({tag, ":settled"}, {62'd0, busy, done}, 64'd0);
   endtask

   initial begin
      logic [OW-1:0] t;
      logic [OW-1:0] s;
      int            d;
      rst_n          = 1'b0;
      enable         = 1'b1;
      u_if.tgt_omega = '0;
      u_if.tgt_step  = '0;
      u_if.tgt_div   = '0;
      u_if.tgt_valid = 1'b0;
      model_reset();
      @(negedge clk);
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      cycle("post_reset");

      // Ramp 0 -> 100 in steps of 10, one update per cycle.
      send("t1_xfer", 64'd100, 64'd10, 0);
      run_idle("t1", 40);
      chk("t1_final", omega, 64'd100);

      // Back to 0 immediately, then a clamped slow ramp to 25.
      send("t2_jump", 64'd0, 64'd0, 0);
      run_idle("t2_jump", 5);
      send("t2_xfer", 64'd25, 64'd10, 3);
      run_idle("t2", 40);
      chk("t2_final", omega, 64'd25);

      // Descend 1000 -> 0 in steps of 300 without wrapping.
      send("t3_jump", 64'd1000, 64'd0, 0);
      run_idle("t3_jump", 5);
      send("t3_xfer", 64'd0, 64'd300, 0);
      run_idle("t3", 20);
      chk("t3_final", omega, 64'd0);

      // Zero step: jump to all-ones on the transfer edge.
      send("t4_xfer", MAXV, 64'd0, 0);
      chk("t4_jump", omega, MAXV);
      run_idle("t4", 5);

      // Equal target: DONE then IDLE with no ramp.
      send("t4_eq", MAXV, 64'd5, 2);
      run_idle("t4_eq", 5);

      // Retarget on a tick edge, then freeze with enable low, then resume.
      send("t5_jump", 64'd0, 64'd0, 0);
      run_idle("t5_jump", 5);
      send("t5_xfer", 64'd1000, 64'd10, 2);
      for (int i = 0; i < 5; i++) cycle("t5_ramp");
      send("t5_retgt", 64'd3, 64'd7, 1);
      chk("t5_no_upd", omega, 64'd10);
      cycle("t5_ramp2");
      enable = 1'b0;
      for (int i = 0; i < 5; i++) cycle("t5_frozen");
      chk("t5_frozen_val", omega, 64'd10);
      enable = 1'b1;
      run_idle("t5", 40);
      chk("t5_final", omega, 64'd3);

      // Asynchronous reset in the middle of a ramp.
      send("t6_xfer", 64'd5000, 64'd10, 0);
      for (int i = 0; i < 7; i++) cycle("t6_ramp");
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("t6_async_omega", omega, 64'd0);
      chk("t6_async_busy", {63'd0, busy}, 64'd0);
      chk("t6_async_done", {63'd0, done}, 64'd0);
      @(negedge clk);
      check_outputs("t6_held");
      rst_n = 1'b1;
      cycle("t6_release");

      // Randomized ramps with occasional mid-ramp retargets and enable gaps.
      for (int n = 0; n < 12; n++) begin
         d = int'($urandom_range(0, 2000));
         if ($urandom_range(0, 1) == 1 && m_om <= MAXV - OW'(d)) t = m_om + OW'(d);
         else if (m_om >= OW'(d))                                t = m_om - OW'(d);
         else                                                    t = m_om + OW'(d);
         s = ($urandom_range(0, 7) == 0) ? 64'd0 : OW'($urandom_range(20, 300));
         send("rnd_xfer", t, s, int'($urandom_range(0, 3)));
         for (int i = 0; i < 1500; i++) begin
            if (m_mode == M_IDLE) break;
            enable = ($urandom_range(0, 99) < 85);
            if (m_mode == M_RAMP && $urandom_range(0, 39) == 0) begin
               t = m_om + OW'($urandom_range(0, 500));
               send("rnd_retgt", t, OW'($urandom_range(20, 300)), int'($urandom_range(0, 3)));
            end else begin
               cycle("rnd");
            end
         end
         enable = 1'b1;
         run_idle("rnd", 1500);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
